hazard_controller: RTL and testbench

//  Central stall/flush/forward sequencer for the 5-stage pipeline (F/D/E/M/W).

---
 rtl/riscv_hazard_pkg.sv | 16 +
 rtl/hazard_forward.sv | 17 +
 rtl/hazard_controller.sv | 151 +++++++++++++++
 tb/tb_hazard_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and FSM states.
package riscv_hazard_pkg;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_LU_STALL = 2'b01,
    HZ_MEM_WAIT = 2'b10
  } hz_state_e;
endpackage

// File: rtl/hazard_forward.sv
// Forwarding select for one E-stage source operand; M-stage result beats W-stage result.
module hazard_forward
  import riscv_hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_we_m,
  input  logic                  reg_we_w,
  output fwd_sel_e              sel
);
  always_comb begin
    sel = FWD_RF;
    if (reg_we_w && (rd_w != '0) && (rd_w == rs)) sel = FWD_W;
    if (reg_we_m && (rd_m != '0) && (rd_m == rs)) sel = FWD_M;
  end
endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencer for the 5-stage pipeline.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_controller
  import riscv_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_D,
  input  logic [REG_ADDR_W-1:0] rs2_D,
  input  logic [REG_ADDR_W-1:0] rs1_E,
  input  logic [REG_ADDR_W-1:0] rs2_E,
  input  logic [REG_ADDR_W-1:0] rd_E,
  input  logic [REG_ADDR_W-1:0] rd_M,
  input  logic [REG_ADDR_W-1:0] rd_W,
  input  logic                  reg_we_E,
  input  logic                  reg_we_M,
  input  logic                  reg_we_W,
  input  logic                  result_src_E,
  input  logic                  pc_src_M,
  input  logic                  dmem_req_M,
  input  logic                  dmem_ready_M,
  output logic [1:0]            fwd_A_E,
  output logic [1:0]            fwd_B_E,
  output logic                  stall_F,
  output logic                  stall_D,
  output logic                  stall_E,
  output logic                  stall_M,
  output logic                  flush_D,
  output logic                  flush_E,
  output logic                  flush_W,
  output logic [1:0]            hz_state,
`ifdef HAZARD_PERF_EN
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt,
`endif
  output logic                  mem_timeout
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(MEM_TIMEOUT - 1);

  fwd_sel_e        fwd_a, fwd_b;
  hz_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            lu, mw;

  hazard_forward u_fwd_a (
    .rs(rs1_E), .rd_m(rd_M), .rd_w(rd_W),
    .reg_we_m(reg_we_M), .reg_we_w(reg_we_W), .sel(fwd_a)
  );
  hazard_forward u_fwd_b (
    .rs(rs2_E), .rd_m(rd_M), .rd_w(rd_W),
    .reg_we_m(reg_we_M), .reg_we_w(reg_we_W), .sel(fwd_b)
  );

  assign lu = result_src_E && reg_we_E && (rd_E != '0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
  assign mw = dmem_req_M && !dmem_ready_M;

  // Outputs are gated by rst so an asserted reset silences them without waiting for a clock.
  always_comb begin
    fwd_A_E = FWD_RF;
    fwd_B_E = FWD_RF;
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (rst) begin
      fwd_A_E = fwd_a;
      fwd_B_E = fwd_b;
      if (mw) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (pc_src_M) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (lu) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN: begin
        if (mw) state_d = HZ_MEM_WAIT;
        else if (lu && !pc_src_M) state_d = HZ_LU_STALL;
      end
      HZ_LU_STALL: state_d = HZ_RUN;
      HZ_MEM_WAIT: if (dmem_ready_M) state_d = HZ_RUN;
      default:     state_d = HZ_RUN;
    endcase
    // Wait counter only runs while memory is stalling and saturates at the limit.
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (mw) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      if (cnt_q >= CNT_THR) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HZ_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign hz_state    = state_q;
  assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] pstall_q, pstall_d, pflush_q, pflush_d;

  always_comb begin
    pstall_d = pstall_q;
    pflush_d = pflush_q;
    if (stall_F && (pstall_q != '1)) pstall_d = pstall_q + 32'd1;
    if ((flush_D || flush_E) && (pflush_q != '1)) pflush_d = pflush_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pstall_q <= '0;
      pflush_q <= '0;
    end else begin
      pstall_q <= pstall_d;
      pflush_q <= pflush_d;
    end
  end

  assign perf_stall_cnt = pstall_q;
  assign perf_flush_cnt = pflush_q;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: per-cycle reference model plus directed literal checks.
module tb_hazard_controller;
  localparam int MT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       reg_we_E, reg_we_M, reg_we_W, result_src_E, pc_src_M, dmem_req_M, dmem_ready_M;
  logic [1:0] fwd_A_E, fwd_B_E, hz_state;
  logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .reg_we_E(reg_we_E), .reg_we_M(reg_we_M), .reg_we_W(reg_we_W),
    .result_src_E(result_src_E), .pc_src_M(pc_src_M),
    .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
    .fwd_A_E(fwd_A_E), .fwd_B_E(fwd_B_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .hz_state(hz_state),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .mem_timeout(mem_timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be, derived from the hazard rules.
  int m_st, m_waits, m_to;
  longint m_pstall, m_pflush;

  function automatic int fsel(input logic [4:0] rs);
    if (reg_we_M && rd_M != 0 && rd_M == rs) return 2;
    if (reg_we_W && rd_W != 0 && rd_W == rs) return 1;
    return 0;
  endfunction

  function automatic bit is_mw();
    return dmem_req_M && !dmem_ready_M;
  endfunction

  function automatic bit is_lu();
    return result_src_E && reg_we_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
  endfunction

  // 3 = memory wait, 2 = branch flush, 1 = load-use stall, 0 = nothing
  function automatic int mode();
    if (!rst) return 0;
    if (is_mw()) return 3;
    if (pc_src_M) return 2;
    if (is_lu()) return 1;
    return 0;
  endfunction

  function automatic int next_st(input int s);
    if (s == 0) return is_mw() ? 2 : ((is_lu() && !pc_src_M) ? 1 : 0);
    if (s == 1) return 0;
    return dmem_ready_M ? 0 : 2;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st <= 0; m_waits <= 0; m_to <= 0; m_pstall <= 0; m_pflush <= 0;
    end else begin
      m_st     <= next_st(m_st);
      m_waits  <= is_mw() ? m_waits + 1 : 0;
      if (is_mw() && m_waits + 1 >= MT) m_to <= 1;
      m_pstall <= m_pstall + ((mode() == 3 || mode() == 1) ? 1 : 0);
      m_pflush <= m_pflush + ((mode() == 2 || mode() == 1) ? 1 : 0);
    end
  end

  always @(negedge clk) begin
    chk("fwd_A_E", fwd_A_E, rst ? fsel(rs1_E) : 0);
    chk("fwd_B_E", fwd_B_E, rst ? fsel(rs2_E) : 0);
    chk("stall_F", stall_F, (mode() == 3 || mode() == 1) ? 1 : 0);
    chk("stall_D", stall_D, (mode() == 3 || mode() == 1) ? 1 : 0);
    chk("stall_E", stall_E, (mode() == 3) ? 1 : 0);
    chk("stall_M", stall_M, (mode() == 3) ? 1 : 0);
    chk("flush_D", flush_D, (mode() == 2) ? 1 : 0);
    chk("flush_E", flush_E, (mode() == 2 || mode() == 1) ? 1 : 0);
    chk("flush_W", flush_W, (mode() == 3) ? 1 : 0);
    chk("hz_state", hz_state, m_st);
    chk("mem_timeout", mem_timeout, m_to);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, m_pstall);
    chk("perf_flush_cnt", perf_flush_cnt, m_pflush);
`endif
  end

  task automatic clear_in();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    reg_we_E = 0; reg_we_M = 0; reg_we_W = 0; result_src_E = 0; pc_src_M = 0;
    dmem_req_M = 0; dmem_ready_M = 0;
  endtask

  task automatic set_lu();
    result_src_E = 1; reg_we_E = 1; rd_E = 7; rs2_D = 7;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    clear_in();
    repeat (2) @(posedge clk);
    smp();
    chk("reset stall_F", stall_F, 0);
    chk("reset hz_state", hz_state, 0);
    chk("reset mem_timeout", mem_timeout, 0);
    nxt(); rst = 1;

    // Forwarding priority and x0 exclusion
    rs1_E = 5; rd_M = 5; reg_we_M = 1; rd_W = 5; reg_we_W = 1;
    smp(); chk("fwd M", fwd_A_E, 2);
    nxt(); reg_we_M = 0;
    smp(); chk("fwd W", fwd_A_E, 1);
    nxt(); reg_we_M = 1; rd_M = 0; rd_W = 0;
    smp(); chk("fwd x0", fwd_A_E, 0);
    nxt(); clear_in(); rs2_E = 9; rd_W = 9; reg_we_W = 1;
    smp(); chk("fwd B W", fwd_B_E, 1);

    // Load-use stall
    nxt(); clear_in(); set_lu();
    smp();
    chk("lu stall_F", stall_F, 1); chk("lu stall_D", stall_D, 1);
    chk("lu flush_E", flush_E, 1); chk("lu hz_state", hz_state, 0);
    nxt(); clear_in();
    smp(); chk("lu after hz_state", hz_state, 1); chk("lu after stall_F", stall_F, 0);
    nxt();
    smp(); chk("lu back hz_state", hz_state, 0);

    // Branch overrides load-use
    nxt(); set_lu(); pc_src_M = 1;
    smp();
    chk("br flush_D", flush_D, 1); chk("br flush_E", flush_E, 1); chk("br stall_F", stall_F, 0);
    nxt(); clear_in();
    smp(); chk("br next hz_state", hz_state, 0);

    // Short memory wait
    nxt(); dmem_req_M = 1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("mw stall_F", stall_F, 1); chk("mw stall_M", stall_M, 1); chk("mw flush_W", flush_W, 1);
      nxt();
    end
    dmem_ready_M = 1;
    smp();
    chk("mw ready stall_F", stall_F, 0); chk("mw ready hz_state", hz_state, 2);
    chk("mw ready mem_timeout", mem_timeout, 0);
    nxt(); clear_in();
    smp(); chk("mw exit hz_state", hz_state, 0);

    // Timeout after MT wait cycles, sticky through ready
    nxt(); dmem_req_M = 1;
    for (int i = 1; i <= 6; i++) begin
      smp();
      if (i == 3) chk("to early", mem_timeout, 0);
      if (i >= 5) chk("to set", mem_timeout, 1);
      nxt();
    end
    dmem_ready_M = 1;
    smp(); chk("to sticky", mem_timeout, 1); chk("to ready stall_F", stall_F, 0);
    nxt(); dmem_ready_M = 0;
    smp(); chk("rewait stall_F", stall_F, 1);
    nxt(); rst = 0; #1;
    chk("async rst stall_F", stall_F, 0); chk("async rst stall_M", stall_M, 0);
    chk("async rst flush_W", flush_W, 0); chk("async rst hz_state", hz_state, 0);
    chk("async rst mem_timeout", mem_timeout, 0);
    clear_in();
    nxt(); rst = 1;

    // Two load-use stalls and one branch
    nxt(); set_lu();
    nxt(); clear_in();
    nxt(); set_lu();
    nxt(); clear_in();
    nxt(); pc_src_M = 1;
    nxt(); clear_in();
    smp();
    chk("seq hz_state", hz_state, 0);
`ifdef HAZARD_PERF_EN
    chk("perf stall", perf_stall_cnt, 2);
    chk("perf flush", perf_flush_cnt, 3);
`endif
    repeat (2) nxt();
    smp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
